// File: rtl/cpu_pkg.sv
// Shared types for the EX/MEM boundary: condition codes and NZCV flags.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam nzcv_t NZCV_RESET = '0;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX->MEM pipeline register.
interface ex_mem_stage_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) ();

    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic              ex_negative;
    logic              ex_zero;
    logic              ex_overflow;
    logic              ex_carry_out;
    logic              ex_set_flags;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_is_bcond;
    logic              ex_is_cbz;
    logic [3:0]        ex_cond;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_result;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic [DATA_W-1:0] mem_store_data;
    logic [3:0]        flags_nzcv;
    logic              branch_taken;

    modport master (
        output stall, flush, ex_valid, ex_result,
        output ex_negative, ex_zero, ex_overflow, ex_carry_out,
        output ex_set_flags, ex_rd, ex_reg_write,
        output ex_mem_read, ex_mem_write, ex_store_data,
        output ex_is_bcond, ex_is_cbz, ex_cond,
        input  mem_valid, mem_result, mem_rd, mem_reg_write,
        input  mem_mem_read, mem_mem_write, mem_store_data,
        input  flags_nzcv, branch_taken
    );

    modport slave (
        input  stall, flush, ex_valid, ex_result,
        input  ex_negative, ex_zero, ex_overflow, ex_carry_out,
        input  ex_set_flags, ex_rd, ex_reg_write,
        input  ex_mem_read, ex_mem_write, ex_store_data,
        input  ex_is_bcond, ex_is_cbz, ex_cond,
        output mem_valid, mem_result, mem_rd, mem_reg_write,
        output mem_mem_read, mem_mem_write, mem_store_data,
        output flags_nzcv, branch_taken
    );

endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code check of a B.cond against the NZCV flags.
module cond_eval
    import cpu_pkg::*;
(
    input  cond_e i_cond,
    input  nzcv_t i_flags,
    output logic  o_taken
);

    always_comb begin
        o_taken = 1'b0;
        unique case (i_cond)
            EQ: o_taken = i_flags.z;
            NE: o_taken = ~i_flags.z;
            CS: o_taken = i_flags.c;
            CC: o_taken = ~i_flags.c;
            MI: o_taken = i_flags.n;
            PL: o_taken = ~i_flags.n;
            VS: o_taken = i_flags.v;
            VC: o_taken = ~i_flags.v;
            HI: o_taken = i_flags.c & ~i_flags.z;
            LS: o_taken = ~i_flags.c | i_flags.z;
            GE: o_taken = (i_flags.n == i_flags.v);
            LT: o_taken = (i_flags.n != i_flags.v);
            GT: o_taken = ~i_flags.z & (i_flags.n == i_flags.v);
            LE: o_taken = i_flags.z | (i_flags.n != i_flags.v);
            AL: o_taken = 1'b1;
            NV: o_taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with the architectural NZCV flags and
// EX-stage resolution of B.cond / CBZ.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input logic           clk,
    input logic           rst_n,
    ex_mem_stage_if.slave bus
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_store_data;
    nzcv_t             r_flags;

    logic              w_set_flags;
    logic              w_bcond_hit;
    cond_e             w_cond;

    assign w_set_flags = bus.ex_valid & bus.ex_set_flags;
    assign w_cond      = cond_e'(bus.ex_cond);

    // Flush outranks stall; flags only move on an edge that accepts EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_store_data <= '0;
            r_flags      <= NZCV_RESET;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!bus.stall) begin
            r_valid      <= bus.ex_valid;
            r_result     <= bus.ex_result;
            r_rd         <= bus.ex_rd;
            r_reg_write  <= bus.ex_valid & bus.ex_reg_write;
            r_mem_read   <= bus.ex_valid & bus.ex_mem_read;
            r_mem_write  <= bus.ex_valid & bus.ex_mem_write;
            r_store_data <= bus.ex_store_data;
            if (w_set_flags) begin
                r_flags <= {bus.ex_negative, bus.ex_zero,
                            bus.ex_carry_out, bus.ex_overflow};
            end
        end
    end

    // B.cond reads the registered flags, never the live ALU flags.
    cond_eval u_cond_eval (
        .i_cond  (w_cond),
        .i_flags (r_flags),
        .o_taken (w_bcond_hit)
    );

    assign bus.branch_taken = bus.ex_valid & ~bus.flush &
                              ((bus.ex_is_cbz & bus.ex_zero) |
                               (bus.ex_is_bcond & w_bcond_hit));

    assign bus.mem_valid      = r_valid;
    assign bus.mem_result     = r_result;
    assign bus.mem_rd         = r_rd;
    assign bus.mem_reg_write  = r_reg_write;
    assign bus.mem_mem_read   = r_mem_read;
    assign bus.mem_mem_write  = r_mem_write;
    assign bus.mem_store_data = r_store_data;
    assign bus.flags_nzcv     = r_flags;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors, queued expectations.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        logic        setf;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] sd;
        logic        bcond;
        logic        cbz;
        logic [3:0]  cond;
    } stim_t;

    typedef struct {
        string       nm;
        logic        mv;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] sd;
        logic [3:0]  fl;
        logic        chk;
    } exp_t;

    typedef struct {
        string nm;
        logic  br;
    } br_t;

    exp_t q_reg[$];
    br_t  q_br[$];
    logic q_rst[$];

    int   n_checks = 0;
    int   n_errors = 0;

    exp_t prev;
    logic have_prev = 1'b0;

    function automatic stim_t mk_alu(logic v, logic [63:0] res,
                                     logic [4:0] rd, logic rw, logic mr,
                                     logic mw, logic [63:0] sd);
        stim_t s;
        s = '0;
        s.valid = v; s.res = res; s.rd = rd;
        s.rw = rw; s.mr = mr; s.mw = mw; s.sd = sd;
        return s;
    endfunction

    function automatic stim_t mk_subs(logic v, logic [63:0] res,
                                      logic [4:0] rd, logic [3:0] f);
        stim_t s;
        s = '0;
        s.valid = v; s.setf = 1'b1; s.rw = 1'b1;
        s.res = res; s.rd = rd;
        {s.n, s.z, s.c, s.v} = f;
        return s;
    endfunction

    function automatic stim_t mk_bcc(logic v, cond_e c);
        stim_t s;
        s = '0;
        s.valid = v; s.bcond = 1'b1; s.cond = c;
        return s;
    endfunction

    function automatic stim_t mk_cbz(logic v, logic z);
        stim_t s;
        s = '0;
        s.valid = v; s.cbz = 1'b1; s.z = z;
        return s;
    endfunction

    function automatic exp_t ex(logic mv, logic [63:0] res, logic [4:0] rd,
                                logic rw, logic mr, logic mw,
                                logic [63:0] sd, logic [3:0] fl, logic chk);
        exp_t e;
        e.nm = ""; e.mv = mv; e.res = res; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.sd = sd;
        e.fl = fl; e.chk = chk;
        return e;
    endfunction

    function automatic exp_t nop(logic mv, logic [3:0] fl);
        return ex(mv, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, fl, 1'b1);
    endfunction

    task automatic drive(input stim_t s);
        bus.stall         = s.stall;
        bus.flush         = s.flush;
        bus.ex_valid      = s.valid;
        bus.ex_result     = s.res;
        bus.ex_negative   = s.n;
        bus.ex_zero       = s.z;
        bus.ex_carry_out  = s.c;
        bus.ex_overflow   = s.v;
        bus.ex_set_flags  = s.setf;
        bus.ex_rd         = s.rd;
        bus.ex_reg_write  = s.rw;
        bus.ex_mem_read   = s.mr;
        bus.ex_mem_write  = s.mw;
        bus.ex_store_data = s.sd;
        bus.ex_is_bcond   = s.bcond;
        bus.ex_is_cbz     = s.cbz;
        bus.ex_cond       = s.cond;
    endtask

    // Register expectation of a vector is queued once its capturing edge has passed.
    task automatic apply(input string nm, input stim_t s, input logic br,
                         input exp_t e);
        br_t b;
        @(posedge clk);
        #2;
        if (have_prev) q_reg.push_back(prev);
        drive(s);
        b.nm = nm;
        b.br = br;
        q_br.push_back(b);
        e.nm = nm;
        prev = e;
        have_prev = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        br_t  b;
        logic bad;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk === 1'b1) begin
                if (q_rst.size() > 0) begin
                    void'(q_rst.pop_front());
                    #1;
                    n_checks++;
                    bad = (bus.mem_valid !== 1'b0) ||
                          (bus.mem_result !== 64'h0) ||
                          (bus.mem_rd !== 5'd0) ||
                          (bus.mem_reg_write !== 1'b0) ||
                          (bus.mem_mem_read !== 1'b0) ||
                          (bus.mem_mem_write !== 1'b0) ||
                          (bus.mem_store_data !== 64'h0) ||
                          (bus.flags_nzcv !== 4'b0000);
                    if (bad) begin
                        n_errors++;
                        $display("FAIL async_reset got v=%b res=%h rd=%0d ctl=%b%b%b sd=%h nzcv=%b required all zero",
                                 bus.mem_valid, bus.mem_result, bus.mem_rd,
                                 bus.mem_reg_write, bus.mem_mem_read,
                                 bus.mem_mem_write, bus.mem_store_data,
                                 bus.flags_nzcv);
                    end
                end
            end else begin
                if (q_br.size() > 0) begin
                    b = q_br.pop_front();
                    n_checks++;
                    if (bus.branch_taken !== b.br) begin
                        n_errors++;
                        $display("FAIL %s branch_taken got %b required %b",
                                 b.nm, bus.branch_taken, b.br);
                    end
                end
                if (q_reg.size() > 0) begin
                    e = q_reg.pop_front();
                    n_checks++;
                    bad = (bus.mem_valid !== e.mv) ||
                          (bus.mem_reg_write !== e.rw) ||
                          (bus.mem_mem_read !== e.mr) ||
                          (bus.mem_mem_write !== e.mw) ||
                          (bus.flags_nzcv !== e.fl) ||
                          (e.chk && ((bus.mem_result !== e.res) ||
                                     (bus.mem_rd !== e.rd) ||
                                     (bus.mem_store_data !== e.sd)));
                    if (bad) begin
                        n_errors++;
                        $display("FAIL %s regs got v=%b res=%h rd=%0d ctl=%b%b%b sd=%h nzcv=%b required v=%b res=%h rd=%0d ctl=%b%b%b sd=%h nzcv=%b",
                                 e.nm, bus.mem_valid, bus.mem_result,
                                 bus.mem_rd, bus.mem_reg_write,
                                 bus.mem_mem_read, bus.mem_mem_write,
                                 bus.mem_store_data, bus.flags_nzcv,
                                 e.mv, e.res, e.rd, e.rw, e.mr, e.mw,
                                 e.sd, e.fl);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        exp_t  r0;
        rst_n = 1'b0;
        drive('0);
        #2;
        r0 = nop(1'b0, 4'b0000);
        r0.nm = "reset_state";
        q_reg.push_back(r0);
        #10;
        rst_n = 1'b1;

        apply("add", mk_alu(1, 64'h1111, 5'd3, 1, 0, 0, 64'hAA), 1'b0,
              ex(1, 64'h1111, 5'd3, 1, 0, 0, 64'hAA, 4'b0000, 1));
        apply("store", mk_alu(1, 64'h2000, 5'd0, 0, 0, 1, 64'hDEAD), 1'b0,
              ex(1, 64'h2000, 5'd0, 0, 0, 1, 64'hDEAD, 4'b0000, 1));
        apply("load", mk_alu(1, 64'h2008, 5'd6, 1, 1, 0, 64'h0), 1'b0,
              ex(1, 64'h2008, 5'd6, 1, 1, 0, 64'h0, 4'b0000, 1));
        apply("bubble", mk_alu(0, 64'h3333, 5'd7, 1, 1, 1, 64'h5), 1'b0,
              ex(0, 64'h3333, 5'd7, 0, 0, 0, 64'h5, 4'b0000, 1));
        apply("subs_1_4", mk_subs(1, 64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 4'b1000),
              1'b0,
              ex(1, 64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 1, 0, 0, 64'h0, 4'b1000, 1));
        s = mk_alu(1, 64'h0, 5'd4, 1, 0, 0, 64'h0);
        {s.n, s.z, s.c, s.v} = 4'b0111;
        apply("add_noset", s, 1'b0,
              ex(1, 64'h0, 5'd4, 1, 0, 0, 64'h0, 4'b1000, 1));
        apply("setf_bubble", mk_subs(0, 64'h9, 5'd1, 4'b0111), 1'b0,
              ex(0, 64'h9, 5'd1, 0, 0, 0, 64'h0, 4'b1000, 1));
        apply("subs_eq", mk_subs(1, 64'h0, 5'd5, 4'b0100), 1'b0,
              ex(1, 64'h0, 5'd5, 1, 0, 0, 64'h0, 4'b0100, 1));
        apply("b_eq", mk_bcc(1, EQ), 1'b1, nop(1, 4'b0100));
        apply("b_ne", mk_bcc(1, NE), 1'b0, nop(1, 4'b0100));
        apply("b_nv", mk_bcc(1, NV), 1'b1, nop(1, 4'b0100));
        apply("b_al_bubble", mk_bcc(0, AL), 1'b0, nop(0, 4'b0100));
        s = mk_bcc(1, EQ);
        s.flush = 1'b1;
        apply("b_eq_flush", s, 1'b0,
              ex(0, 64'h0, 5'd0, 0, 0, 0, 64'h0, 4'b0100, 0));
        apply("subs_nv", mk_subs(1, 64'h10, 5'd8, 4'b1001), 1'b0,
              ex(1, 64'h10, 5'd8, 1, 0, 0, 64'h0, 4'b1001, 1));
        apply("b_ge", mk_bcc(1, GE), 1'b1, nop(1, 4'b1001));
        apply("b_lt", mk_bcc(1, LT), 1'b0, nop(1, 4'b1001));
        apply("b_gt", mk_bcc(1, GT), 1'b1, nop(1, 4'b1001));
        apply("b_le", mk_bcc(1, LE), 1'b0, nop(1, 4'b1001));
        apply("subs_c", mk_subs(1, 64'h20, 5'd9, 4'b0010), 1'b0,
              ex(1, 64'h20, 5'd9, 1, 0, 0, 64'h0, 4'b0010, 1));
        apply("b_hi", mk_bcc(1, HI), 1'b1, nop(1, 4'b0010));
        apply("b_ls", mk_bcc(1, LS), 1'b0, nop(1, 4'b0010));
        apply("b_cs", mk_bcc(1, CS), 1'b1, nop(1, 4'b0010));
        apply("b_cc", mk_bcc(1, CC), 1'b0, nop(1, 4'b0010));
        apply("pre_stall", mk_alu(1, 64'h55, 5'd10, 1, 0, 0, 64'h66), 1'b0,
              ex(1, 64'h55, 5'd10, 1, 0, 0, 64'h66, 4'b0010, 1));
        s = mk_subs(1, 64'h77, 5'd11, 4'b0110);
        s.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply("stall", s, 1'b0,
                  ex(1, 64'h55, 5'd10, 1, 0, 0, 64'h66, 4'b0010, 1));
        end
        s.stall = 1'b0;
        apply("unstall", s, 1'b0,
              ex(1, 64'h77, 5'd11, 1, 0, 0, 64'h0, 4'b0110, 1));
        s = mk_subs(1, 64'h88, 5'd12, 4'b1111);
        s.stall = 1'b1;
        s.flush = 1'b1;
        apply("flush_stall", s, 1'b0,
              ex(0, 64'h0, 5'd0, 0, 0, 0, 64'h0, 4'b0110, 0));
        apply("cbz_taken", mk_cbz(1, 1), 1'b1, nop(1, 4'b0110));
        apply("cbz_bubble", mk_cbz(0, 1), 1'b0, nop(0, 4'b0110));
        apply("cbz_nonzero", mk_cbz(1, 0), 1'b0, nop(1, 4'b0110));
        apply("pre_reset", mk_alu(1, 64'hABCD, 5'd13, 1, 0, 1, 64'hEF), 1'b0,
              ex(1, 64'hABCD, 5'd13, 1, 0, 1, 64'hEF, 4'b0110, 1));

        @(posedge clk);
        #2;
        q_reg.push_back(prev);
        have_prev = 1'b0;
        s = '0;
        s.stall = 1'b1;
        drive(s);
        @(posedge clk);
        #3;
        q_rst.push_back(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive('0);

        for (int i = 0; i < 10; i++) begin
            if (q_reg.size() == 0 && q_br.size() == 0 && q_rst.size() == 0)
                break;
            @(negedge clk);
        end
        if (q_reg.size() != 0 || q_br.size() != 0 || q_rst.size() != 0) begin
            $display("FAIL drain got %0d pending required 0",
                     q_reg.size() + q_br.size() + q_rst.size());
            $fatal(1, "scoreboard did not drain");
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
